// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM source/consumer and pwm_capture.
// master drives pwm_in and reads results; slave is the capture block.
interface pwm_capture_if #(
    parameter int unsigned CNT_W = 16
);
    logic             pwm_in;
    logic [CNT_W-1:0] period_len;
    logic [CNT_W-1:0] high_len;
    logic [3:0]       duty_tenths;
    logic             meas_valid;
    logic             signal_static;
    logic             overrun;

    modport master (
        output pwm_in,
        input  period_len, high_len, duty_tenths, meas_valid, signal_static, overrun
    );

    modport slave (
        input  pwm_in,
        output period_len, high_len, duty_tenths, meas_valid, signal_static, overrun
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures period/high time of an async PWM input and reports duty in tenths.
// Optional 3-sample glitch filter enabled by defining PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    pwm_capture_if.slave bus
);
    localparam int unsigned    REM_W = CNT_W + 4;
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
    localparam logic [3:0]    LAST_ITER = 4'd9;

    typedef enum logic {ST_IDLE, ST_DIVIDE} state_t;

    state_t state_q, state_d;

    logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic             lvl_c, rise_c, start_c, last_iter_c, timeout_c;
    logic [CNT_W-1:0] pcnt_q, pcnt_d, hcnt_q, hcnt_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] per_q, per_d, hi_q, hi_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [3:0]       quo_q, quo_d, iter_q, iter_d;
    logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
    logic [3:0]       duty_q, duty_d;
    logic             valid_q, valid_d, static_q, static_d, ovr_q, ovr_d;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // Level follows s2 only after three equal consecutive samples.
    logic h1_q, h1_d, h2_q, h2_d, filt_q, filt_d;

    always_comb begin
        h1_d   = s2_q;
        h2_d   = h1_q;
        lvl_c  = ((s2_q == h1_q) && (h1_q == h2_q)) ? s2_q : filt_q;
        filt_d = lvl_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1_q   <= 1'b0;
            h2_q   <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            h1_q   <= h1_d;
            h2_q   <= h2_d;
            filt_q <= filt_d;
        end
    end
`else
    assign lvl_c = s2_q;
`endif

    assign rise_c      = lvl_c & ~s3_q;
    assign start_c     = (state_q == ST_IDLE) && rise_c && armed_q;
    assign last_iter_c = (state_q == ST_DIVIDE) && (iter_q == LAST_ITER);
    // A rise in the same cycle as saturation is a valid (long) period, not a timeout.
    assign timeout_c   = armed_q && (state_q == ST_IDLE) && !rise_c && (pcnt_q == TMO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_c)     state_d = ST_DIVIDE;
            ST_DIVIDE: if (last_iter_c) state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s1_d     = bus.pwm_in;
        s2_d     = s1_q;
        s3_d     = lvl_c;
        pcnt_d   = rise_c ? CNT_W'(1) : ((pcnt_q == TMO) ? pcnt_q : pcnt_q + CNT_W'(1));
        hcnt_d   = rise_c ? CNT_W'(1) :
                   ((lvl_c && (hcnt_q != TMO)) ? hcnt_q + CNT_W'(1) : hcnt_q);
        armed_d  = armed_q;
        per_d    = per_q;
        hi_d     = hi_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        iter_d   = iter_q;
        period_d = period_q;
        high_d   = high_q;
        duty_d   = duty_q;
        static_d = static_q;
        valid_d  = 1'b0;
        ovr_d    = 1'b0;

        if (rise_c && !armed_q) begin
            armed_d  = 1'b1;
            static_d = 1'b0;
        end

        if (timeout_c) begin
            armed_d  = 1'b0;
            static_d = 1'b1;
            period_d = '0;
            high_d   = '0;
            duty_d   = lvl_c ? 4'd10 : 4'd0;
            valid_d  = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    per_d  = pcnt_q;
                    hi_d   = hcnt_q;
                    rem_d  = REM_W'(hcnt_q) * REM_W'(10) + REM_W'(pcnt_q >> 1);
                    quo_d  = 4'd0;
                    iter_d = 4'd0;
                end
            end
            ST_DIVIDE: begin
                ovr_d = rise_c;
                if (rem_q >= REM_W'(per_q)) begin
                    rem_d = rem_q - REM_W'(per_q);
                    quo_d = quo_q + 4'd1;
                end
                iter_d = iter_q + 4'd1;
                if (last_iter_c) begin
                    period_d = per_q;
                    high_d   = hi_q;
                    duty_d   = quo_d;
                    valid_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            pcnt_q   <= '0;
            hcnt_q   <= '0;
            armed_q  <= 1'b0;
            per_q    <= '0;
            hi_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            iter_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            duty_q   <= '0;
            valid_q  <= 1'b0;
            static_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            pcnt_q   <= pcnt_d;
            hcnt_q   <= hcnt_d;
            armed_q  <= armed_d;
            per_q    <= per_d;
            hi_q     <= hi_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            iter_q   <= iter_d;
            period_q <= period_d;
            high_q   <= high_d;
            duty_q   <= duty_d;
            valid_q  <= valid_d;
            static_q <= static_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.period_len    = period_q;
    assign bus.high_len      = high_q;
    assign bus.duty_tenths   = duty_q;
    assign bus.meas_valid    = valid_q;
    assign bus.signal_static = static_q;
    assign bus.overrun       = ovr_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: per-cycle expected pulse schedule built from the input timeline.
module tb_pwm_capture;
    localparam int TMO = 1000;
    localparam int N   = 4096;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int LAT = 2;
    localparam int SH  = 3;   // shortest high time that passes the filter
    localparam int SD  = 4;   // (30+3)/7
`else
    localparam int LAT = 0;
    localparam int SH  = 2;
    localparam int SD  = 3;   // (20+3)/7
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   cyc, n_cmp, n_err, r, c;

    bit        ev [N];
    bit        eo [N];
    bit [15:0] ep [N];
    bit [15:0] eh [N];
    bit [3:0]  ed [N];

    pwm_capture_if #(.CNT_W(16)) bus ();

    pwm_capture #(.CNT_W(16), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Input driven after edge c rises internally at c+2+LAT; result visible after edge c+13+LAT.
    task automatic expect_meas(input int cr, input int p, input int h, input int d);
        int i;
        i = cr + 13 + LAT;
        if (i < N) begin
            ev[i] = 1'b1; ep[i] = 16'(p); eh[i] = 16'(h); ed[i] = 4'(d);
        end
    endtask

    task automatic expect_ovr(input int cr);
        if (cr + 3 + LAT < N) eo[cr + 3 + LAT] = 1'b1;
    endtask

    task automatic expect_tmo(input int cr, input int d);
        int i;
        i = cr + 3 + LAT + TMO;
        if (i < N) begin
            ev[i] = 1'b1; ep[i] = 16'd0; eh[i] = 16'd0; ed[i] = 4'(d);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc < N) begin
            check("meas_valid", 32'(bus.meas_valid), 32'(ev[cyc]));
            check("overrun", 32'(bus.overrun), 32'(eo[cyc]));
            if (ev[cyc]) begin
                check("period_len", 32'(bus.period_len), 32'(ep[cyc]));
                check("high_len", 32'(bus.high_len), 32'(eh[cyc]));
                check("duty_tenths", 32'(bus.duty_tenths), 32'(ed[cyc]));
            end
        end
    endtask

    // n periods of p cycles, high for h; optional 2-cycle low glitch at offset g.
    task automatic wave(input int p, input int h, input int n, input int g);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < p; i++) begin
                bus.pwm_in = (i < h) && !((g >= 0) && ((i == g) || (i == g + 1)));
                tick();
            end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_period"}, 32'(bus.period_len), 32'd0);
        check({tag, "_high"},   32'(bus.high_len), 32'd0);
        check({tag, "_duty"},   32'(bus.duty_tenths), 32'd0);
        check({tag, "_valid"},  32'(bus.meas_valid), 32'd0);
        check({tag, "_static"}, 32'(bus.signal_static), 32'd0);
        check({tag, "_ovr"},    32'(bus.overrun), 32'd0);
    endtask

    initial begin
        cyc = 0; n_cmp = 0; n_err = 0;
        rst_n = 1'b0;
        bus.pwm_in = 1'b0;
        repeat (3) tick();
        check_zero_outputs("reset");
        #2 rst_n = 1'b1;
        repeat (3) tick();

        // P=20 H=10: first rise arms only
        r = cyc;
        for (int k = 1; k <= 5; k++) expect_meas(r + 20 * k, 20, 10, 5);
        wave(20, 10, 6, -1);
        check("static_a", 32'(bus.signal_static), 32'd0);

        // P=20 H=6
        r = cyc;
        expect_meas(r, 20, 10, 5);
        for (int k = 1; k <= 3; k++) expect_meas(r + 20 * k, 20, 6, 3);
        wave(20, 6, 4, -1);

        // P=7: every other rise lands inside the divide
        r = cyc;
        expect_meas(r, 20, 6, 3);
        expect_ovr(r + 7);
        expect_meas(r + 14, 7, SH, SD);
        expect_ovr(r + 21);
        expect_meas(r + 28, 7, SH, SD);
        expect_ovr(r + 35);
        wave(7, SH, 6, -1);

        // P=14 H=4 -> 47/14 = 3
        r = cyc;
        expect_meas(r, 7, SH, SD);
        expect_meas(r + 14, 14, 4, 3);
        expect_meas(r + 28, 14, 4, 3);
        wave(14, 4, 3, -1);

        // held high -> timeout with duty 10
        r = cyc;
        expect_meas(r, 14, 4, 3);
        expect_tmo(r, 10);
        bus.pwm_in = 1'b1;
        repeat (TMO + 40) tick();
        check("static_hi", 32'(bus.signal_static), 32'd1);

        // re-arm then measure again
        bus.pwm_in = 1'b0;
        repeat (5) tick();
        r = cyc;
        for (int k = 1; k <= 3; k++) expect_meas(r + 20 * k, 20, 10, 5);
        wave(20, 10, 4, -1);
        check("static_rearm", 32'(bus.signal_static), 32'd0);

        // held low -> timeout with duty 0
        expect_tmo(r + 60, 0);
        repeat (TMO + 20) tick();
        check("static_lo", 32'(bus.signal_static), 32'd1);

        // reset in the middle of a divide
        r = cyc;
        expect_meas(r + 20, 20, 10, 5);
        wave(20, 10, 2, -1);
        bus.pwm_in = 1'b1;
        c = cyc;
        while (cyc < c + 7 + LAT) tick();
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid_rst");
        bus.pwm_in = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        r = cyc;
        expect_meas(r + 20, 20, 10, 5);
        expect_meas(r + 40, 20, 10, 5);
        wave(20, 10, 3, -1);
        repeat (15) tick();

        // P=40 H=20 with a 2-cycle low glitch at offset 8
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        r = cyc;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        expect_meas(r + 40, 40, 20, 5);
        expect_meas(r + 80, 40, 20, 5);
`else
        expect_meas(r + 10, 10, 8, 8);
        expect_meas(r + 40, 30, 10, 3);
        expect_ovr(r + 50);
        expect_meas(r + 80, 30, 10, 3);
        expect_ovr(r + 90);
`endif
        wave(40, 20, 3, 8);
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
